// File: rtl/capt_fifo_gearbox_pkg.sv
// Shared definitions for the capture FIFO gearbox: legal beat widths, stored-word
// sideband layout and width helpers used by the top and the FIFO core.
package capt_fifo_gearbox_pkg;

    localparam int OUT_W_NARROW = 8;
    localparam int OUT_W_WIDE   = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Stored word = {eob, sob, payload}
    function automatic int sob_bit(input int data_w);
        return data_w;
    endfunction

    function automatic int eob_bit(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int cnt_w(input int depth, input int data_w, input int out_w);
        return clog2(depth) + clog2(data_w / out_w) + 1;
    endfunction

endpackage

// File: rtl/capt_fifo_gearbox_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head word is visible the cycle
// after it is written. Flush clears the pointers and occupancy synchronously.
module sync_fifo_fwft
    import capt_fifo_gearbox_pkg::*;
#(
    parameter int WIDTH    = 34,
    parameter int DEPTH    = 512,
    parameter int AFULL_TH = 496
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [clog2(DEPTH):0]  count_nxt_o,
    output logic                   full_o,
    output logic                   afull_o,
    output logic                   empty_o
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign count_nxt_o = count_d;
    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign afull_o     = (count_q >= (AW+1)'(AFULL_TH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/capt_fifo_gearbox.sv
// Capture FIFO with width-down gearbox: stores DATA_W words with burst flags and
// delivers OUT_W beats lane 0 first, with beat count, byte count, checksum and error flags.
module capt_fifo_gearbox
    import capt_fifo_gearbox_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 8,
    parameter int DEPTH    = 512,
    parameter int AFULL_TH = 496
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [DATA_W-1:0]                     wr_data,
    input  logic                                  wr_sob,
    input  logic                                  wr_eob,
    output logic                                  full,
    output logic                                  afull,
    input  logic                                  flush,
    input  logic                                  rd_en,
    output logic                                  rd_vld,
    output logic [OUT_W-1:0]                      rd_data,
    output logic                                  rd_sob,
    output logic                                  rd_eob,
    output logic [cnt_w(DEPTH,DATA_W,OUT_W)-1:0]  rd_cnt,
    input  logic                                  clr_stat,
    output logic [31:0]                           byte_cntr,
    output logic [15:0]                           chk_sum,
    output logic                                  overrun,
    output logic                                  underrun
);
    localparam int RATIO = DATA_W / OUT_W;
    localparam int LW    = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;
    localparam int AW    = clog2(DEPTH);
    localparam int CW    = cnt_w(DEPTH, DATA_W, OUT_W);
    localparam int WW    = DATA_W + 2;

    logic [WW-1:0] head;
    logic [AW:0]   cnt_nxt;
    logic          empty, push, beat_fire, head_pop, add_en;
    logic [LW-1:0] lane_q, lane_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [31:0]   byte_q, byte_d;
    logic [15:0]   sum_q, sum_d, half_w;
    logic          ovr_q, ovr_d, und_q, und_d;
    logic [7:0]    even_q;

    // Full is sampled before this cycle's pop, so a write while full is always dropped
    assign push      = wr_en && !full && !flush;
    assign beat_fire = rd_en && rd_vld && !flush;
    assign head_pop  = beat_fire && (lane_q == LW'(RATIO-1));

    sync_fifo_fwft #(
        .WIDTH    (WW),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (push),
        .pop_i       (head_pop),
        .wdata_i     ({wr_eob, wr_sob, wr_data}),
        .head_o      (head),
        .count_nxt_o (cnt_nxt),
        .full_o      (full),
        .afull_o     (afull),
        .empty_o     (empty)
    );

    assign rd_vld  = !empty;
    assign rd_data = rd_vld ? head[lane_q*OUT_W +: OUT_W] : '0;
    assign rd_sob  = rd_vld && (lane_q == '0) && head[sob_bit(DATA_W)];
    assign rd_eob  = rd_vld && (lane_q == LW'(RATIO-1)) && head[eob_bit(DATA_W)];

    // Narrow beats pair into little-endian halfwords; the pair closes on an odd lane
    always_comb begin
        if (OUT_W == OUT_W_WIDE) half_w = 16'(rd_data);
        else                     half_w = {rd_data[7:0], even_q};
        add_en = beat_fire && ((OUT_W == OUT_W_WIDE) || lane_q[0]);
    end

    always_comb begin
        lane_d = lane_q;
        byte_d = byte_q;
        sum_d  = sum_q;
        ovr_d  = ovr_q;
        und_d  = und_q;
        if (flush)          lane_d = '0;
        else if (head_pop)  lane_d = '0;
        else if (beat_fire) lane_d = lane_q + 1'b1;
        if (beat_fire)                      byte_d = byte_q + 32'(OUT_W / 8);
        if (add_en)                         sum_d  = sum_q + half_w;
        if (wr_en && full && !flush)        ovr_d  = 1'b1;
        if (rd_en && !rd_vld && !flush)     und_d  = 1'b1;
        if (clr_stat) begin
            byte_d = '0;
            sum_d  = '0;
            ovr_d  = 1'b0;
            und_d  = 1'b0;
        end
        rd_cnt_d = CW'(cnt_nxt * RATIO) - CW'(lane_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q   <= '0;
            rd_cnt_q <= '0;
            byte_q   <= '0;
            sum_q    <= '0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            rd_cnt_q <= rd_cnt_d;
            byte_q   <= byte_d;
            sum_q    <= sum_d;
            ovr_q    <= ovr_d;
            und_q    <= und_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_fire && !lane_q[0]) even_q <= rd_data[7:0];
    end

    assign rd_cnt    = rd_cnt_q;
    assign byte_cntr = byte_q;
    assign chk_sum   = sum_q;
    assign overrun   = ovr_q;
    assign underrun  = und_q;

endmodule

// File: tb/tb_capt_fifo_gearbox.sv
// Bench for capt_fifo_gearbox: an 8-bit-beat build and a 16-bit-beat build,
// checked against a beat scoreboard and a small statistics model.
module tb_capt_fifo_gearbox;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit beat build
    logic we8 = 0, ws8 = 0, wb8 = 0, fl8 = 0, re8 = 0, clr8 = 0;
    logic [31:0] wd8 = '0;
    logic full8, afull8, vld8, sob8, eob8, ovr8, und8;
    logic [7:0]  dat8;
    logic [11:0] cnt8;
    logic [31:0] bytes8;
    logic [15:0] sum8;

    // 16-bit beat build
    logic we16 = 0, fl16 = 0, re16 = 0, clr16 = 0;
    logic [31:0] wd16 = '0;
    logic full16, afull16, vld16, sob16, eob16, ovr16, und16;
    logic [15:0] dat16;
    logic [10:0] cnt16;
    logic [31:0] bytes16;
    logic [15:0] sum16;

    capt_fifo_gearbox #(.DATA_W(32), .OUT_W(8), .DEPTH(512), .AFULL_TH(496)) dut8 (
        .clk(clk), .rst_n(rst_n), .wr_en(we8), .wr_data(wd8), .wr_sob(ws8), .wr_eob(wb8),
        .full(full8), .afull(afull8), .flush(fl8), .rd_en(re8), .rd_vld(vld8), .rd_data(dat8),
        .rd_sob(sob8), .rd_eob(eob8), .rd_cnt(cnt8), .clr_stat(clr8), .byte_cntr(bytes8),
        .chk_sum(sum8), .overrun(ovr8), .underrun(und8));

    capt_fifo_gearbox #(.DATA_W(32), .OUT_W(16), .DEPTH(512), .AFULL_TH(496)) dut16 (
        .clk(clk), .rst_n(rst_n), .wr_en(we16), .wr_data(wd16), .wr_sob(1'b0), .wr_eob(1'b0),
        .full(full16), .afull(afull16), .flush(fl16), .rd_en(re16), .rd_vld(vld16), .rd_data(dat16),
        .rd_sob(sob16), .rd_eob(eob16), .rd_cnt(cnt16), .clr_stat(clr16), .byte_cntr(bytes16),
        .chk_sum(sum16), .overrun(ovr16), .underrun(und16));

    int errs = 0;
    int checks = 0;

    // Scoreboard entries: {sob, eob, byte}
    logic [9:0]  exp8[$];
    logic [15:0] exp16[$];
    int          m_lane = 0;
    logic [31:0] m_bytes = '0;
    logic [15:0] m_sum = '0;
    logic [7:0]  m_prev = '0;
    logic        m_ovr = 0, m_und = 0;

    task automatic cyc8(input bit we, input logic [31:0] wd, input bit s, input bit e,
                        input bit re, input bit fl, input bit clr);
        int words;
        logic [9:0] b;
        words = (exp8.size() + m_lane) / 4;
        if (fl) begin
            exp8.delete();
            m_lane = 0;
        end else begin
            if (re) begin
                if (exp8.size() > 0) begin
                    b = exp8.pop_front();
                    m_bytes = m_bytes + 1;
                    if (m_lane % 2 == 1) m_sum = m_sum + {b[7:0], m_prev};
                    else                 m_prev = b[7:0];
                    m_lane = (m_lane + 1) % 4;
                end else m_und = 1;
            end
            if (we) begin
                if (words == 512) m_ovr = 1;
                else for (int i = 0; i < 4; i++)
                    exp8.push_back({(i == 0) && s, (i == 3) && e, wd[i*8 +: 8]});
            end
        end
        if (clr) begin
            m_bytes = '0; m_sum = '0; m_ovr = 0; m_und = 0;
        end
        we8 = we; wd8 = wd; ws8 = s; wb8 = e; re8 = re; fl8 = fl; clr8 = clr;
        @(posedge clk); #1;
        we8 = 0; wd8 = '0; ws8 = 0; wb8 = 0; re8 = 0; fl8 = 0; clr8 = 0;
    endtask

    task automatic cyc16(input bit we, input logic [31:0] wd, input bit re);
        if (re && exp16.size() > 0) void'(exp16.pop_front());
        if (we) begin
            exp16.push_back(wd[15:0]);
            exp16.push_back(wd[31:16]);
        end
        we16 = we; wd16 = wd; re16 = re;
        @(posedge clk); #1;
        we16 = 0; wd16 = '0; re16 = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({vld8, dat8, sob8, eob8, full8, afull8, ovr8, und8} !== '0) begin errs++;
            $display("FAIL reset_flags8: got %h required 0", {vld8, dat8, sob8, eob8, full8, afull8, ovr8, und8}); end
        checks++; if ({cnt8, bytes8, sum8} !== '0) begin errs++;
            $display("FAIL reset_stats8: got %h required 0", {cnt8, bytes8, sum8}); end
        checks++; if ({vld16, dat16, cnt16, bytes16, sum16} !== '0) begin errs++;
            $display("FAIL reset_16: got %h required 0", {vld16, dat16, cnt16, bytes16, sum16}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        logic [7:0] beats [4];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        cyc8(1, 32'h44332211, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (exp8.size() == 0 || {vld8, sob8, eob8, dat8} !== {1'b1, exp8[0]}) begin errs++;
                $display("FAIL single_beat%0d: got vld=%b sob=%b eob=%b data=%h", i, vld8, sob8, eob8, dat8); end
            checks++; if (dat8 !== beats[i]) begin errs++;
                $display("FAIL single_data%0d: got %h required %h", i, dat8, beats[i]); end
            cyc8(0, '0, 0, 0, 1, 0, 0);
        end
        checks++; if (bytes8 !== 32'd4) begin errs++; $display("FAIL single_bytes: got %0d required 4", bytes8); end
        checks++; if (sum8 !== 16'h6644) begin errs++; $display("FAIL single_sum: got %h required 6644", sum8); end
        checks++; if (vld8 !== 1'b0) begin errs++; $display("FAIL single_drained: got vld=%b required 0", vld8); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 512; i++) begin
            cyc8(1, 32'(i) * 32'h01010101, 0, 0, 0, 0, 0);
            if (i == 494) begin
                checks++; if (afull8 !== 1'b0) begin errs++; $display("FAIL afull_495: got %b required 0", afull8); end
            end
            if (i == 495) begin
                checks++; if (afull8 !== 1'b1) begin errs++; $display("FAIL afull_496: got %b required 1", afull8); end
            end
            if (i == 510) begin
                checks++; if (full8 !== 1'b0) begin errs++; $display("FAIL full_511: got %b required 0", full8); end
            end
        end
        checks++; if (full8 !== 1'b1) begin errs++; $display("FAIL full_512: got %b required 1", full8); end
        checks++; if (cnt8 !== 12'd2048) begin errs++; $display("FAIL cnt_full: got %0d required 2048", cnt8); end
        cyc8(1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        checks++; if (ovr8 !== 1'b1) begin errs++; $display("FAIL overrun_set: got %b required 1", ovr8); end
        checks++; if (cnt8 !== 12'(exp8.size())) begin errs++;
            $display("FAIL cnt_after_drop: got %0d required %0d", cnt8, exp8.size()); end
        cyc8(0, '0, 0, 0, 0, 0, 1);
        checks++; if ({ovr8, bytes8, sum8} !== '0) begin errs++;
            $display("FAIL clr_stat: got ovr=%b bytes=%0d sum=%h required 0", ovr8, bytes8, sum8); end
        checks++; if (cnt8 !== 12'd2048) begin errs++; $display("FAIL clr_keeps_data: got %0d required 2048", cnt8); end
        cyc8(0, '0, 0, 0, 0, 1, 0);
        checks++; if ({vld8, cnt8, full8, afull8} !== '0) begin errs++;
            $display("FAIL flush_full: got vld=%b cnt=%0d full=%b afull=%b", vld8, cnt8, full8, afull8); end
    endtask

    task automatic test_partial_and_underrun();
        for (int i = 0; i < 3; i++) cyc8(1, 32'hA0B0C0D0 + 32'(i), 0, 0, 0, 0, 0);
        cyc8(0, '0, 0, 0, 1, 0, 0);
        checks++; if (cnt8 !== 12'd11) begin errs++; $display("FAIL cnt_11: got %0d required 11", cnt8); end
        for (int i = 0; i < 11; i++) begin
            checks++; if (exp8.size() == 0 || {vld8, sob8, eob8, dat8} !== {1'b1, exp8[0]}) begin errs++;
                $display("FAIL drain_beat%0d: got vld=%b data=%h", i, vld8, dat8); end
            cyc8(0, '0, 0, 0, 1, 0, 0);
        end
        checks++; if (und8 !== 1'b0) begin errs++; $display("FAIL underrun_clear: got %b required 0", und8); end
        cyc8(0, '0, 0, 0, 1, 0, 0);
        checks++; if (und8 !== 1'b1) begin errs++; $display("FAIL underrun_set: got %b required 1", und8); end
        checks++; if (cnt8 !== 12'd0) begin errs++; $display("FAIL cnt_after_underrun: got %0d required 0", cnt8); end
        checks++; if (bytes8 !== m_bytes || sum8 !== m_sum) begin errs++;
            $display("FAIL stats_drain: got bytes=%0d sum=%h required bytes=%0d sum=%h", bytes8, sum8, m_bytes, m_sum); end
        cyc8(0, '0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_flush_mid_word();
        cyc8(1, 32'h87654321, 1, 0, 0, 0, 0);
        cyc8(0, '0, 0, 0, 1, 0, 0);
        cyc8(0, '0, 0, 0, 1, 0, 0);
        cyc8(1, 32'h12345678, 0, 0, 1, 1, 0);
        checks++; if ({vld8, cnt8} !== '0) begin errs++; $display("FAIL flush_empty: got vld=%b cnt=%0d required 0", vld8, cnt8); end
        checks++; if ({ovr8, und8} !== 2'b00) begin errs++; $display("FAIL flush_no_err: got ovr=%b und=%b", ovr8, und8); end
        checks++; if (bytes8 !== m_bytes) begin errs++; $display("FAIL flush_keeps_bytes: got %0d required %0d", bytes8, m_bytes); end
        cyc8(1, 32'hDDCCBBAA, 1, 1, 0, 0, 0);
        checks++; if ({vld8, sob8, dat8} !== {2'b11, 8'hAA}) begin errs++;
            $display("FAIL flush_first_beat: got vld=%b sob=%b data=%h required 1 1 aa", vld8, sob8, dat8); end
        checks++; if (cnt8 !== 12'd4) begin errs++; $display("FAIL flush_cnt4: got %0d required 4", cnt8); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (exp8.size() == 0 || {vld8, sob8, eob8, dat8} !== {1'b1, exp8[0]}) begin errs++;
                $display("FAIL flush_beat%0d: got sob=%b eob=%b data=%h", i, sob8, eob8, dat8); end
            cyc8(0, '0, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        cyc8(0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            checks++; if (cnt8 !== 12'(exp8.size()) || vld8 !== (exp8.size() != 0)) begin errs++;
                $display("FAIL b2b_cnt%0d: got cnt=%0d vld=%b required %0d", i, cnt8, vld8, exp8.size()); end
            if (exp8.size() != 0) begin
                checks++; if ({sob8, eob8, dat8} !== exp8[0]) begin errs++;
                    $display("FAIL b2b_beat%0d: got %h required %h", i, {sob8, eob8, dat8}, exp8[0]); end
            end
            cyc8((i % 4 == 0) && i < 32, $urandom, i % 8 == 0, i % 8 == 4, (i % 3) != 2 || i >= 32, 0, 0);
        end
        checks++; if (bytes8 !== m_bytes || sum8 !== m_sum) begin errs++;
            $display("FAIL b2b_stats: got bytes=%0d sum=%h required bytes=%0d sum=%h", bytes8, sum8, m_bytes, m_sum); end
        checks++; if (ovr8 !== m_ovr || und8 !== m_und) begin errs++;
            $display("FAIL b2b_flags: got ovr=%b und=%b required %b %b", ovr8, und8, m_ovr, m_und); end
    endtask

    task automatic test_wide_beats();
        logic [15:0] beats [4];
        beats[0] = 16'h2211; beats[1] = 16'h4433; beats[2] = 16'hFFFF; beats[3] = 16'h0000;
        cyc16(1, 32'h44332211, 0);
        cyc16(1, 32'h0000FFFF, 0);
        checks++; if (cnt16 !== 11'd4) begin errs++; $display("FAIL wide_cnt: got %0d required 4", cnt16); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (exp16.size() == 0 || {vld16, dat16} !== {1'b1, exp16[0]} || dat16 !== beats[i]) begin errs++;
                $display("FAIL wide_beat%0d: got vld=%b data=%h required %h", i, vld16, dat16, beats[i]); end
            cyc16(0, '0, 1);
        end
        checks++; if (sum16 !== 16'h6643) begin errs++; $display("FAIL wide_sum: got %h required 6643", sum16); end
        checks++; if (bytes16 !== 32'd8) begin errs++; $display("FAIL wide_bytes: got %0d required 8", bytes16); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cyc8(1, 32'h5A5A0000 + 32'(i), 1, 1, 0, 0, 0);
        cyc8(0, '0, 0, 0, 1, 0, 1);
        re8 = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({vld8, dat8, sob8, eob8, full8, afull8, ovr8, und8} !== '0) begin errs++;
            $display("FAIL async_flags: got %h required 0", {vld8, dat8, sob8, eob8, full8, afull8, ovr8, und8}); end
        checks++; if ({cnt8, bytes8, sum8} !== '0) begin errs++;
            $display("FAIL async_stats: got cnt=%0d bytes=%0d sum=%h required 0", cnt8, bytes8, sum8); end
        re8 = 1'b0;
        exp8.delete(); m_lane = 0; m_bytes = '0; m_sum = '0; m_ovr = 0; m_und = 0;
        exp16.delete();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({vld8, cnt8} !== '0) begin errs++; $display("FAIL async_release: got vld=%b cnt=%0d", vld8, cnt8); end
        cyc8(1, 32'h0403020F, 1, 0, 0, 0, 0);
        checks++; if ({vld8, sob8, dat8, cnt8} !== {2'b11, 8'h0F, 12'd4}) begin errs++;
            $display("FAIL async_fresh: got vld=%b sob=%b data=%h cnt=%0d", vld8, sob8, dat8, cnt8); end
        cyc8(0, '0, 0, 0, 1, 0, 0);
        checks++; if (dat8 !== 8'h02 || bytes8 !== 32'd1) begin errs++;
            $display("FAIL async_pop: got data=%h bytes=%0d required 02 1", dat8, bytes8); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_partial_and_underrun();
        test_flush_mid_word();
        test_back_to_back();
        test_wide_beats();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/capt_fifo_gearbox.md
Name: capt_fifo_gearbox

Overview:
Parametrised single-clock capture FIFO with an integrated width-down converter. It is the next-generation replacement for the fixed 36-to-8 capture path. Upstream writes DATA_W-bit words with start/end-of-burst sidebands. The register/SPI side pops OUT_W-bit beats, lane 0 first. The block also provides occupancy in beats, byte counting, 16-bit checksum, sticky error flags and a synchronous flush.

Parameters:
DATA_W, 32, payload bits per stored word; must be a multiple of 16 and of OUT_W.
OUT_W, 8, output beat width; legal values 8 or 16.
DEPTH, 512, storage depth in words; must be a power of 2, at least 4.
AFULL_TH, 496, afull asserts when occupancy >= AFULL_TH words.

Ports:
clk  in  1  sole clock.
rst_n  in  1  asynchronous, active-low reset.
wr_en  in  1  write strobe.
wr_data  in  DATA_W  payload word.
wr_sob  in  1  start-of-burst flag stored with the word.
wr_eob  in  1  end-of-burst flag stored with the word.
full  out  1  occupancy == DEPTH.
afull  out  1  occupancy >= AFULL_TH.
flush  in  1  synchronous pulse; discards all stored data.
rd_en  in  1  beat pop request.
rd_vld  out  1  beat available (FWFT).
rd_data  out  OUT_W  current beat.
rd_sob  out  1  set on first beat of an sob word.
rd_eob  out  1  set on last beat of an eob word.
rd_cnt  out  CW  beats available; CW = clog2(DEPTH)+clog2(DATA_W/OUT_W)+1.
clr_stat  in  1  synchronous pulse; clears statistics and error flags.
byte_cntr  out  32  bytes popped since last clear.
chk_sum  out  16  running checksum.
overrun  out  1  sticky: a write was attempted while full.
underrun  out  1  sticky: a pop was attempted while not rd_vld.

Behaviour:
- Reset: asynchronous on rst_n low. All outputs go to 0 (rd_data 0, full 0, afull 0, rd_cnt 0). Pointers and lane counter clear. Storage contents are don't-care.
- RATIO = DATA_W/OUT_W. The lane counter runs 0..RATIO-1.
- Read data: rd_data = head_word[lane*OUT_W +: OUT_W]. It is combinational from the head word and the lane counter.
- rd_vld: equals !empty.
- Pop: a beat is consumed when rd_en && rd_vld. The lane then increments. The head word is popped when lane == RATIO-1, and lane wraps to 0.
- Underrun: rd_en && !rd_vld is ignored, and underrun is set.
- Write: the word is stored when wr_en && !full. full is evaluated before this cycle's pop. A write while full is dropped and overrun is set, even if a pop happens in the same cycle.
- Write-to-read latency: 1 cycle. A write to an empty FIFO raises rd_vld on the next edge.
- Simultaneous write and pop of the head word when neither full nor empty: occupancy is unchanged.
- rd_cnt = occupancy*RATIO - lane. It is registered and consistent with rd_vld in the same cycle.
- Sidebands:
  - rd_sob = rd_vld && lane==0 && head.sob.
  - rd_eob = rd_vld && lane==RATIO-1 && head.eob.
  - A word with both flags set shows sob on its first beat and eob on its last beat.
- byte_cntr: adds OUT_W/8 per consumed beat. Wraps at 2^32.
- chk_sum: wrapping 16-bit addition of halfwords, little-endian.
  - OUT_W=16: each consumed beat is added.
  - OUT_W=8: {odd beat, even beat} is added on each odd lane consume.
  - An odd trailing byte is never added.
- clr_stat:
  - Clears byte_cntr, chk_sum, overrun and underrun on the next edge.
  - Wins over a same-cycle increment or error set.
  - Does not touch the data path.
- flush:
  - Empties the FIFO and zeros the lane counter on the next edge.
  - Takes priority over same-cycle wr_en and rd_en; those are dropped and set no error flags.
  - Does not clear statistics.

Decomposition:
- Shared package/defines:
  - legal OUT_W values;
  - stored-word layout: sob bit at DATA_W, eob bit at DATA_W+1;
  - a clog2 helper;
  - the CW width function.
- One sub-module, sync_fifo_fwft: DEPTH x (DATA_W+2) storage, pointers, occupancy, full/afull/empty, 1-cycle FWFT head.
- The gearbox, statistics and flags live in the top module.

Test Plan:
1. DATA_W=32, OUT_W=8; write 0x44332211 with sob=eob=1; pop 4 beats.
   - Beats are 11, 22, 33, 44.
   - rd_sob is set on beat 0 only; rd_eob on beat 3 only.
   - byte_cntr=4, chk_sum=0x6644.
2. Write 512 words without reading, then perform a 513th write.
   - afull rises on the edge storing word 496.
   - full is set at 512.
   - The 513th write is dropped, overrun=1, rd_cnt=2048.
   - Then pulse clr_stat: overrun=0, byte_cntr=0.
3. Write 3 words, pop 1 beat.
   - rd_cnt=11.
   - Popping on empty (after draining all 12 beats) sets underrun=1, and rd_cnt stays 0.
4. Start the pop of word A mid-word (lane=2), then pulse flush together with wr_en.
   - Next cycle: rd_vld=0, rd_cnt=0, lane=0, and the word is not stored.
   - Then write 0xDDCCBBAA: the first beat is AA.
5. OUT_W=16 build; write 0x44332211 then 0x0000FFFF; pop all beats.
   - Beats are 2211, 4433, FFFF, 0000.
   - chk_sum=(0x2211+0x4433+0xFFFF) mod 2^16=0x6643, byte_cntr=8.
6. Drive rst_n low asynchronously mid-pop (between edges) with 5 words stored.
   - All outputs are 0 immediately, with no clock edge needed.
   - After release, rd_vld=0 and a fresh write/read works.
